leaf_user_zip2: RTL

- User-side kernel stage for an i2o1 leaf page.
- Consumes the two 32-bit input streams delivered by the leaf interface (interface2user_1/_2) and produces the single output stream returned to it (user2interface_1).
- Combines the streams either element-wise (sum) or by strict interleave. Each input and the output is buffered, so no combinational path runs from an input to an ack.

---
 rtl/leaf_user_pkg.sv | 15 +
 rtl/leaf_user_zip2_if.sv | 38 +++
 rtl/leaf_user_skid_fifo.sv | 56 +++++
 rtl/leaf_user_zip2.sv | 128 ++++++++++++
 4 files changed

// File: rtl/leaf_user_pkg.sv
// Shared definitions for the leaf user-side kernel stages: default word width,
// combine-mode selectors and the interleave FSM states.
package leaf_user_pkg;

    localparam int DEF_PAYLOAD_BITS = 32;

    localparam int MODE_SUM        = 0;
    localparam int MODE_INTERLEAVE = 1;

    typedef enum logic {
        TAKE1 = 1'b0,
        TAKE2 = 1'b1
    } take_state_e;

endpackage

// File: rtl/leaf_user_zip2_if.sv
// Two-input / one-output valid-ack stream bundle between the leaf interface
// (master, drives the input streams) and the user kernel (slave).
interface leaf_user_zip2_if
    import leaf_user_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS
);
    logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_1;
    logic                    vld_interface2user_1;
    logic                    ack_user2interface_1;

    logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_2;
    logic                    vld_interface2user_2;
    logic                    ack_user2interface_2;

    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_1;
    logic                    vld_user2interface_1;
    logic                    ack_interface2user_1;

    modport master (
        output dout_leaf_interface2user_1, vld_interface2user_1,
        input  ack_user2interface_1,
        output dout_leaf_interface2user_2, vld_interface2user_2,
        input  ack_user2interface_2,
        input  din_leaf_user2interface_1, vld_user2interface_1,
        output ack_interface2user_1
    );

    modport slave (
        input  dout_leaf_interface2user_1, vld_interface2user_1,
        output ack_user2interface_1,
        input  dout_leaf_interface2user_2, vld_interface2user_2,
        output ack_user2interface_2,
        output din_leaf_user2interface_1, vld_user2interface_1,
        input  ack_interface2user_1
    );

endinterface

// File: rtl/leaf_user_skid_fifo.sv
// Small power-of-two FIFO whose ready output is registered from the next
// occupancy, so upstream ack never depends on same-cycle push.
module leaf_user_skid_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push_en;
    logic             pop_en;

    // A push while full is dropped: ready was already low that cycle.
    assign push_en    = push & ready;
    assign pop_en     = pop & ~empty;
    assign count_next = count + CW'(push_en) - CW'(pop_en);
    assign empty      = (count == '0);
    assign pop_data   = mem[rd_ptr];

    // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_en);
            rd_ptr <= rd_ptr + AW'(pop_en);
            count  <= count_next;
            ready  <= (count_next != CW'(DEPTH));
        end
    end

    // NOTE: storage is not reset; stale entries are unreachable because empty gates every read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/leaf_user_zip2.sv
// User kernel for an i2o1 leaf page: buffers two input streams and merges them
// into one output stream by element-wise sum or strict in1/in2 interleave.
module leaf_user_zip2
    import leaf_user_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int MODE         = MODE_SUM,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic        clk_user,
    input  logic        reset,
    leaf_user_zip2_if.slave bus,
    output logic [31:0] word_cnt
);
    logic [PAYLOAD_BITS-1:0] data1;
    logic [PAYLOAD_BITS-1:0] data2;
    logic                    empty1;
    logic                    empty2;
    logic                    ready1;
    logic                    ready2;
    logic                    pop1;
    logic                    pop2;

    logic                    load;
    logic [PAYLOAD_BITS-1:0] load_data;
    logic                    can_load;
    logic [PAYLOAD_BITS-1:0] out_data;
    logic                    out_vld;
    logic                    out_fire;

    take_state_e state;
    take_state_e state_next;

    leaf_user_skid_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk       (clk_user),
        .rst_n     (reset),
        .push      (bus.vld_interface2user_1),
        .push_data (bus.dout_leaf_interface2user_1),
        .pop       (pop1),
        .pop_data  (data1),
        .empty     (empty1),
        .ready     (ready1)
    );

    leaf_user_skid_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk       (clk_user),
        .rst_n     (reset),
        .push      (bus.vld_interface2user_2),
        .push_data (bus.dout_leaf_interface2user_2),
        .pop       (pop2),
        .pop_data  (data2),
        .empty     (empty2),
        .ready     (ready2)
    );

    assign bus.ack_user2interface_1      = ready1;
    assign bus.ack_user2interface_2      = ready2;
    assign bus.din_leaf_user2interface_1 = out_data;
    assign bus.vld_user2interface_1      = out_vld;

    assign out_fire = out_vld & bus.ack_interface2user_1;
    assign can_load = ~out_vld | bus.ack_interface2user_1;

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            state <= TAKE1;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop1       = 1'b0;
        pop2       = 1'b0;
        load       = 1'b0;
        load_data  = '0;
        if (MODE == MODE_SUM) begin
            if (!empty1 && !empty2 && can_load) begin
                pop1      = 1'b1;
                pop2      = 1'b1;
                load      = 1'b1;
                load_data = data1 + data2;
            end
        end else begin
            // Strict order: a waiting in1 word never overtakes a missing in2 word.
            case (state)
                TAKE1: begin
                    if (!empty1 && can_load) begin
                        pop1       = 1'b1;
                        load       = 1'b1;
                        load_data  = data1;
                        state_next = TAKE2;
                    end
                end
                TAKE2: begin
                    if (!empty2 && can_load) begin
                        pop2       = 1'b1;
                        load       = 1'b1;
                        load_data  = data2;
                        state_next = TAKE1;
                    end
                end
                default: state_next = TAKE1;
            endcase
        end
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
            out_vld  <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (load) begin
                out_data <= load_data;
                out_vld  <= 1'b1;
            end else if (out_fire) begin
                out_vld  <= 1'b0;
            end
            if (out_fire) begin
                word_cnt <= word_cnt + 32'd1;
            end
        end
    end

endmodule
